// File: rtl/mic_i2s_rx_pkg.sv
// Shared constants, types and helpers for the I2S microphone-array receiver.
package mic_rx_pkg;

   localparam int N_LINES  = 32;
   localparam int N_CHAN   = 64;
   localparam int SAMPLE_W = 16;
   localparam int CHAN_W   = 6;

   localparam int DEF_CLK_DIV      = 16;
   localparam int DEF_SLOT_BITS    = 32;
   localparam int DEF_SAMPLE_BITS  = 16;
   localparam int DEF_SAMPLE_PHASE = 5;

   typedef logic [CHAN_W-1:0]   chan_t;
   typedef logic [SAMPLE_W-1:0] sample_t;

   // Synthetic sample: low frame-count bits above the channel number.
   function automatic sample_t pattern_word(input logic [9:0] fc, input chan_t ch);
      return {fc, ch};
   endfunction

endpackage

// File: rtl/mic_i2s_rx_clkgen.sv
// Bit-clock / word-select generator plus the shift, latch and frame-done
// strobes derived from the position inside the current bit and slot.
module mic_clkgen
   import mic_rx_pkg::*;
#(
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int SLOT_BITS    = DEF_SLOT_BITS,
   parameter int SAMPLE_BITS  = DEF_SAMPLE_BITS,
   parameter int SAMPLE_PHASE = DEF_SAMPLE_PHASE
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic mic_clk,
   output logic mic_ws,
   output logic sample_stb,
   output logic latch_stb,
   output logic frame_done
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(SLOT_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV / 2);
   localparam logic [CNT_W-1:0] PHASE     = CNT_W'(SAMPLE_PHASE);
   localparam logic [BIT_W-1:0] BIT_MAX   = BIT_W'(SLOT_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_SMP   = BIT_W'(SAMPLE_BITS);
   localparam logic [BIT_W-1:0] BIT_LATCH = BIT_W'(SAMPLE_BITS + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic             ws_q, ws_d;
   logic             mic_clk_q, mic_clk_d;
   logic             phase_hit_s;

   // Next bit position; mic_clk is decoded from the next count so it lines up with cnt_q.
   always_comb begin
      cnt_d     = {CNT_W{1'b0}};
      bit_d     = {BIT_W{1'b0}};
      ws_d      = 1'b0;
      mic_clk_d = 1'b0;
      if (enable) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = {CNT_W{1'b0}};
            if (bit_q == BIT_MAX) begin
               bit_d = {BIT_W{1'b0}};
               ws_d  = ~ws_q;
            end else begin
               bit_d = bit_q + 1'b1;
               ws_d  = ws_q;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
            bit_d = bit_q;
            ws_d  = ws_q;
         end
         mic_clk_d = (cnt_d >= CNT_HALF);
      end else begin
         mic_clk_d = 1'b0;
      end
   end

   // Generator state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= {CNT_W{1'b0}};
         bit_q     <= {BIT_W{1'b0}};
         ws_q      <= 1'b0;
         mic_clk_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         ws_q      <= ws_d;
         mic_clk_q <= mic_clk_d;
      end
   end

   // Bit 0 of each slot is the I2S one-bit delay, so shifting starts at bit 1.
   assign phase_hit_s = enable && (cnt_q == PHASE);
   assign sample_stb  = phase_hit_s && (bit_q != {BIT_W{1'b0}}) && (bit_q <= BIT_SMP);
   assign latch_stb   = phase_hit_s && (bit_q == BIT_LATCH);
   assign frame_done  = latch_stb && ws_q;
   assign mic_clk     = mic_clk_q;
   assign mic_ws      = ws_q;

endmodule

// File: rtl/mic_i2s_rx.sv
// 32-line / 64-channel I2S microphone receiver with a one-frame output buffer.
// Optional build macro MIC_RX_TEST_PATTERN_EN adds test_mode and synthetic samples.
module mic_i2s_rx
   import mic_rx_pkg::*;
#(
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int SLOT_BITS    = DEF_SLOT_BITS,
   parameter int SAMPLE_BITS  = DEF_SAMPLE_BITS,
   parameter int SAMPLE_PHASE = DEF_SAMPLE_PHASE
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                clr_overrun,
`ifdef MIC_RX_TEST_PATTERN_EN
   input  logic                test_mode,
`endif
   output logic                mic_clk,
   output logic                mic_ws,
   input  logic [N_LINES-1:0]  mic_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SAMPLE_W-1:0] out_data,
   output logic [CHAN_W-1:0]   out_chan,
   output logic                out_last,
   output logic [15:0]         frame_cnt,
   output logic                overrun
);

   logic    sample_stb, latch_stb, frame_done;
   sample_t sh_q [N_LINES];
   sample_t sh_d [N_LINES];
   sample_t odd_q [N_LINES];
   sample_t odd_d [N_LINES];
   sample_t lat_odd_s [N_LINES];
   sample_t lat_even_s [N_LINES];
   sample_t obuf_q [N_CHAN];
   sample_t obuf_d [N_CHAN];
   logic    busy_q, busy_d, start_q, start_d, overrun_q, overrun_d;
   logic    out_valid_q, out_valid_d, out_last_q, out_last_d;
   sample_t out_data_q, out_data_d;
   chan_t   out_chan_q, out_chan_d, nxt_chan_s;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   mic_clkgen #(
      .CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS),
      .SAMPLE_BITS(SAMPLE_BITS), .SAMPLE_PHASE(SAMPLE_PHASE)
   ) u_clkgen (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .mic_clk(mic_clk), .mic_ws(mic_ws),
      .sample_stb(sample_stb), .latch_stb(latch_stb), .frame_done(frame_done)
   );

   // Value latched per line: shift register, or the synthetic pattern when enabled.
   always_comb begin
      for (int j = 0; j < N_LINES; j++) begin
`ifdef MIC_RX_TEST_PATTERN_EN
         if (test_mode) begin
            lat_odd_s[j]  = pattern_word(frame_cnt_q[9:0], chan_t'(2 * j + 1));
            lat_even_s[j] = pattern_word(frame_cnt_q[9:0], chan_t'(2 * j));
         end else begin
            lat_odd_s[j]  = sh_q[j];
            lat_even_s[j] = sh_q[j];
         end
`else
         lat_odd_s[j]  = sh_q[j];
         lat_even_s[j] = sh_q[j];
`endif
      end
   end

   // Serial capture and odd-channel (ws=0 slot) latch.
   always_comb begin
      for (int j = 0; j < N_LINES; j++) begin
         sh_d[j]  = sh_q[j];
         odd_d[j] = odd_q[j];
         if (!enable) begin
            sh_d[j]  = {SAMPLE_W{1'b0}};
            odd_d[j] = {SAMPLE_W{1'b0}};
         end else if (sample_stb) begin
            sh_d[j] = {sh_q[j][SAMPLE_W-2:0], mic_data[j]};
         end else if (latch_stb && !mic_ws) begin
            odd_d[j] = lat_odd_s[j];
         end else begin
            sh_d[j] = sh_q[j];
         end
      end
   end

   assign nxt_chan_s = out_chan_q + 6'd1;

   // Frame hand-off into the output buffer and channel streaming.
   always_comb begin
      obuf_d      = obuf_q;
      busy_d      = busy_q;
      start_d     = 1'b0;
      overrun_d   = overrun_q;
      out_valid_d = out_valid_q;
      out_chan_d  = out_chan_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      frame_cnt_d = frame_cnt_q;
      // A frame arriving while the buffer still streams is dropped and flagged.
      if (frame_done && busy_q) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
      if (frame_done && !busy_q) begin
         for (int j = 0; j < N_LINES; j++) begin
            obuf_d[2 * j + 1] = odd_q[j];
            obuf_d[2 * j]     = lat_even_s[j];
         end
         busy_d  = 1'b1;
         start_d = 1'b1;
      end else begin
         start_d = 1'b0;
      end
      if (start_q) begin
         out_valid_d = 1'b1;
         out_chan_d  = 6'd0;
         out_data_d  = obuf_q[0];
         out_last_d  = 1'b0;
      end else if (out_valid_q && out_ready) begin
         if (out_last_q) begin
            out_valid_d = 1'b0;
            out_chan_d  = 6'd0;
            out_data_d  = {SAMPLE_W{1'b0}};
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
         end else begin
            out_chan_d = nxt_chan_s;
            out_data_d = obuf_q[nxt_chan_s];
            out_last_d = (nxt_chan_s == 6'd63);
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Datapath and stream registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < N_LINES; j++) begin
            sh_q[j]  <= {SAMPLE_W{1'b0}};
            odd_q[j] <= {SAMPLE_W{1'b0}};
         end
         for (int c = 0; c < N_CHAN; c++) begin
            obuf_q[c] <= {SAMPLE_W{1'b0}};
         end
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         overrun_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_chan_q  <= 6'd0;
         out_data_q  <= {SAMPLE_W{1'b0}};
         out_last_q  <= 1'b0;
         frame_cnt_q <= 16'd0;
      end else begin
         sh_q        <= sh_d;
         odd_q       <= odd_d;
         obuf_q      <= obuf_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         overrun_q   <= overrun_d;
         out_valid_q <= out_valid_d;
         out_chan_q  <= out_chan_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_last  = out_last_q;
   assign frame_cnt = frame_cnt_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_mic_i2s_rx.sv
// Scoreboard bench for mic_i2s_rx: a microphone model drives lines 0 and 31,
// expected channel streams are queued by the stimulus and checked by a monitor.
module tb_mic_i2s_rx;

   typedef struct packed {
      logic [15:0] data;
      logic [5:0]  chan;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n, enable, clr_overrun, out_ready;
   logic        test_mode;
   logic        mic_clk, mic_ws, out_valid, out_last, overrun;
   logic [31:0] mic_data = 32'h8000_0000;
   logic [15:0] out_data, frame_cnt;
   logic [5:0]  out_chan;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   tb_bit  = 0;
   logic [15:0] w0 = 16'hA5C3;
   logic [15:0] w1 = 16'h1234;
   exp_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mic_i2s_rx dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .clr_overrun(clr_overrun),
`ifdef MIC_RX_TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .mic_clk(mic_clk), .mic_ws(mic_ws), .mic_data(mic_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_chan(out_chan), .out_last(out_last), .frame_cnt(frame_cnt), .overrun(overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_valid(input int max_cyc, input string name);
      int n = 0;
      while (out_valid !== 1'b1 && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
      end
      if (out_valid !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: out_valid not seen within %0d cycles", name, max_cyc);
      end
   endtask

   // Line 0 carries a0 in the ws=0 slot and a1 in the ws=1 slot; line 31 is all ones.
   function automatic void push_frame(input logic [15:0] a0, input logic [15:0] a1);
      exp_t e;
      for (int c = 0; c < 64; c++) begin
         e.data = (c == 0) ? a1 : (c == 1) ? a0 : (c >= 62) ? 16'hFFFF : 16'h0000;
         e.chan = 6'(c);
         e.last = (c == 63);
         sb_q.push_back(e);
      end
   endfunction

   function automatic void push_pattern(input logic [9:0] fc);
      exp_t e;
      for (int c = 0; c < 64; c++) begin
         e.data = {fc, 6'(c)};
         e.chan = 6'(c);
         e.last = (c == 63);
         sb_q.push_back(e);
      end
   endfunction

   // Microphone model: new bit after each mic_clk fall, bit 0 at each ws change.
   initial begin
      int nb;
      logic prev_clk, prev_ws;
      logic [15:0] word;
      prev_clk = 1'b0;
      prev_ws  = 1'b0;
      forever begin
         @(negedge clk);
         nb = tb_bit;
         if (reset_n !== 1'b1 || enable !== 1'b1) nb = 0;
         else if (mic_ws !== prev_ws) nb = 0;
         else if (prev_clk === 1'b1 && mic_clk === 1'b0) nb = nb + 1;
         tb_bit   = nb;
         prev_clk = mic_clk;
         prev_ws  = mic_ws;
         word     = (mic_ws === 1'b1) ? w1 : w0;
         mic_data = 32'h8000_0000;
         if (nb >= 1 && nb <= 16) mic_data[0] = word[16 - nb];
      end
   end

   // Monitor: pops the scoreboard on each accepted transfer and checks stall stability.
   initial begin
      exp_t e;
      logic prev_stall;
      logic [15:0] prev_data;
      logic [5:0]  prev_chan;
      prev_stall = 1'b0;
      prev_data  = 16'h0000;
      prev_chan  = 6'd0;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1) begin
            if (prev_stall) begin
               check("stall_valid", out_valid, 32'd1);
               check("stall_data", out_data, prev_data);
               check("stall_chan", out_chan, prev_chan);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
               if (sb_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_sample: chan %0d data 0x%0h, none expected", out_chan, out_data);
               end else begin
                  e = sb_q.pop_front();
                  check($sformatf("data_ch%0d", e.chan), out_data, e.data);
                  check("chan", out_chan, e.chan);
                  check($sformatf("last_ch%0d", e.chan), out_last, e.last);
               end
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data  = out_data;
            prev_chan  = out_chan;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, c0;
      reset_n = 1'b0; enable = 1'b0; clr_overrun = 1'b0; out_ready = 1'b0; test_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mic_clk", mic_clk, 32'd0);
      check("rst_mic_ws", mic_ws, 32'd0);
      check("rst_out_valid", out_valid, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_chan", out_chan, 32'd0);
      check("rst_out_last", out_last, 32'd0);
      check("rst_frame_cnt", frame_cnt, 32'd0);
      check("rst_overrun", overrun, 32'd0);

      // Two frames with ready held high: exact 64-beat bursts and 1024-cycle period.
      reset_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      push_frame(w0, w1);
      push_frame(w0, w1);
      enable = 1'b1;
      wait_valid(2000, "first_frame");
      t1 = cyc;
      for (int i = 0; i < 64; i++) begin
         check("burst_valid", out_valid, 32'd1);
         check("burst_chan", out_chan, 32'(i));
         check("burst_last", out_last, (i == 63) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
      end
      check("burst_end_valid", out_valid, 32'd0);
      check("frame_cnt_1", frame_cnt, 32'd1);
      wait_valid(1100, "second_frame");
      check("frame_period", 32'(cyc - t1), 32'd1024);
      repeat (64) @(posedge clk);
      #1;
      check("frame_cnt_2", frame_cnt, 32'd2);

      // Long stall after channel 0: next frame dropped, stream resumes at channel 1.
      out_ready = 1'b0;
      push_frame(w0, w1);
      wait_valid(1100, "stall_frame");
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (1100) @(posedge clk);
      #1;
      check("overrun_set", overrun, 32'd1);
      check("stalled_valid", out_valid, 32'd1);
      check("stalled_chan", out_chan, 32'd1);
      check("stalled_data", out_data, 32'hA5C3);
      out_ready = 1'b1;
      w0 = 16'h8001;
      w1 = 16'h7FFE;
      push_frame(w0, w1);
      repeat (64) @(posedge clk);
      #1;
      check("frame_cnt_3", frame_cnt, 32'd3);
      check("overrun_sticky", overrun, 32'd1);
      clr_overrun = 1'b1;
      @(posedge clk); #1;
      clr_overrun = 1'b0;
      check("overrun_cleared", overrun, 32'd0);
      wait_valid(1100, "post_drop_frame");
      repeat (64) @(posedge clk);
      #1;
      check("frame_cnt_4", frame_cnt, 32'd4);

      // Enable dropped at bit 10 of the ws=1 slot, restored 50 cycles later.
      for (int n = 0; n < 1100 && !(mic_ws === 1'b1 && tb_bit == 10); n++) begin
         @(posedge clk); #1;
      end
      check("ws1_bit10_found", {mic_ws, 8'(tb_bit)}, {1'b1, 8'd10});
      enable = 1'b0;
      @(posedge clk); #1;
      check("dis_mic_clk", mic_clk, 32'd0);
      check("dis_mic_ws", mic_ws, 32'd0);
      repeat (49) @(posedge clk);
      #1;
      check("dis_no_valid", out_valid, 32'd0);
      check("dis_frame_cnt", frame_cnt, 32'd4);
      push_frame(w0, w1);
      enable = 1'b1;
      c0 = cyc;
      repeat (7) @(posedge clk);
      #1;
      check("restart_clk_low", mic_clk, 32'd0);
      @(posedge clk); #1;
      check("restart_clk_high", mic_clk, 32'd1);
      repeat (503) @(posedge clk);
      #1;
      check("restart_ws_low", mic_ws, 32'd0);
      @(posedge clk); #1;
      check("restart_ws_high", mic_ws, 32'd1);
      wait_valid(400, "restart_frame");
      check("restart_latency", 32'(cyc - c0), 32'd791);
      repeat (64) @(posedge clk);
      #1;
      check("frame_cnt_5", frame_cnt, 32'd5);

      // Asynchronous reset while channel 20 is pending.
      push_frame(w0, w1);
      wait_valid(1100, "reset_frame");
      for (int n = 0; n < 64 && out_chan !== 6'd20; n++) begin
         @(posedge clk); #1;
      end
      check("chan20_reached", out_chan, 32'd20);
      out_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 32'd0);
      check("arst_out_chan", out_chan, 32'd0);
      check("arst_out_data", out_data, 32'd0);
      check("arst_out_last", out_last, 32'd0);
      check("arst_frame_cnt", frame_cnt, 32'd0);
      check("arst_mic_clk", mic_clk, 32'd0);
      check("arst_mic_ws", mic_ws, 32'd0);
      check("arst_overrun", overrun, 32'd0);
      sb_q.delete();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      push_frame(w0, w1);
      wait_valid(2000, "post_reset_frame");
      check("post_reset_chan0", out_chan, 32'd0);
      check("post_reset_data0", out_data, 32'h7FFE);
      repeat (64) @(posedge clk);
      #1;
      check("post_reset_frame_cnt", frame_cnt, 32'd1);

`ifdef MIC_RX_TEST_PATTERN_EN
      // Synthetic samples carry {frame_cnt[9:0], channel}.
      test_mode = 1'b1;
      push_pattern(10'd1);
      wait_valid(1100, "pattern_frame");
      repeat (64) @(posedge clk);
      #1;
      check("pattern_frame_cnt", frame_cnt, 32'd2);
      test_mode = 1'b0;
`endif

      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mic_i2s_rx.md
MIC_I2S_RX -- requirements
Module: mic_i2s_rx

Interface
REQ-001 Parameter CLK_DIV, default 16, clk cycles per mic bit period (even, >=4).
REQ-002 Parameter SLOT_BITS, default 32, bit periods per word-select half-frame.
REQ-003 Parameter SAMPLE_BITS, default 16, bits captured per slot, MSB first.
REQ-004 Parameter SAMPLE_PHASE, default 5, clk count within a bit period at which mic_data is sampled (0..CLK_DIV-1).
REQ-005 clk  in  1  system clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  run capture; low holds the bit-clock generator idle.
REQ-008 clr_overrun  in  1  single-cycle pulse that clears the overrun flag.
REQ-009 mic_clk  out  1  microphone bit clock.
REQ-010 mic_ws  out  1  microphone word select.
REQ-011 mic_data  in  32  one serial line per two microphones.
REQ-012 out_valid  out  1  output sample valid.
REQ-013 out_ready  in  1  downstream accepts the sample.
REQ-014 out_data  out  16  sample value.
REQ-015 out_chan  out  6  channel index 0..63.
REQ-016 out_last  out  1  high with channel 63.
REQ-017 frame_cnt  out  16  count of frames delivered, wrapping.
REQ-018 overrun  out  1  sticky flag: a frame was dropped.

Function
REQ-019 Bit counter cnt runs 0..CLK_DIV-1 while enable is high; mic_clk is low for cnt < CLK_DIV/2 and high otherwise.
REQ-020 Bit index advances 0..SLOT_BITS-1 at cnt wrap; mic_ws toggles when the bit index wraps; frame period = 2*SLOT_BITS*CLK_DIV clk cycles (1024 by default).
REQ-021 At cnt==SAMPLE_PHASE and bit index 1..SAMPLE_BITS, each of the 32 shift registers shifts in its mic_data bit; bit 0 is the I2S one-bit delay and is ignored.
REQ-022 At bit index SAMPLE_BITS+1, cnt==SAMPLE_PHASE, shift register j is latched as channel 2j+1 when mic_ws==0 and as channel 2j when mic_ws==1.
REQ-023 A frame completes when the mic_ws==1 slot latch occurs; the 64 latched samples are then copied to the output buffer in one cycle if the output buffer is idle.
REQ-024 Output streaming: channels 0..63 in order, one per accepted transfer (out_valid & out_ready); out_data/out_chan/out_last stable while out_valid high and out_ready low.
REQ-025 First out_valid asserts exactly 1 cycle after the copy; out_valid deasserts the cycle after channel 63 is accepted; frame_cnt increments on that acceptance.
REQ-026 If a frame completes while the output buffer is still streaming, the new frame is discarded, the in-progress stream is unaffected and overrun sets.
REQ-027 overrun stays set until clr_overrun; if clr_overrun and a new drop coincide, overrun remains set.
REQ-028 enable low: cnt, bit index, shift registers and slot state clear on the next cycle; mic_clk=0, mic_ws=0; an in-progress output stream completes normally.
REQ-029 enable rising: generation restarts from cnt=0, bit 0, mic_ws=0; the first complete frame is the first mic_ws==1 latch after restart.
REQ-030 frame_cnt wraps 0xFFFF -> 0x0000 without side effects.

Reset
REQ-031 Asynchronous reset_n low: mic_clk=0, mic_ws=0, out_valid=0, out_data=0, out_chan=0, out_last=0, frame_cnt=0, overrun=0, all counters and buffers cleared.
REQ-032 Reset asserted mid-stream aborts the stream; no partial frame is emitted after release.

Configuration
REQ-033 Macro MIC_RX_TEST_PATTERN_EN: when defined, an input test_mode (1 bit) is added and, while high, latched samples are replaced by {frame_cnt[9:0], channel[5:0]} with timing unchanged.
REQ-034 Without MIC_RX_TEST_PATTERN_EN, the test_mode port and pattern logic are absent and samples always come from mic_data.

Structure
REQ-035 Package mic_rx_pkg holds N_LINES=32, N_CHAN=64, SAMPLE_W=16, the channel-index type and the default parameter values.
REQ-036 Sub-module mic_clkgen contains cnt, bit index, mic_clk, mic_ws and the sample/latch/frame-done strobes.

Verification
REQ-037 Defaults, mic_data[0] driving 0xA5C3 in ws=0 slot and 0x1234 in ws=1 slot -> channel 1 = 0xA5C3, channel 0 = 0x1234, frame period 1024 cycles.
REQ-038 out_ready held high -> 64 consecutive valid cycles, out_last only on channel 63, frame_cnt +1 per frame.
REQ-039 out_ready low for 1100 cycles after first sample -> next frame dropped, overrun=1, stalled stream resumes at channel 1 unchanged; clr_overrun -> overrun=0.
REQ-040 enable dropped at bit index 10 of ws=1 slot, raised 50 cycles later -> no frame emitted for the partial frame, mic_clk/mic_ws restart from 0.
REQ-041 reset_n pulsed low while channel 20 is pending -> all outputs zero asynchronously, next stream starts at channel 0.
REQ-042 With MIC_RX_TEST_PATTERN_EN and test_mode=1, frame_cnt=3 -> channel 5 data = 0x00C5.
